// File: rtl/receive_engine.sv
// rtl/receive_engine.sv - UART receiver: synchronized Rx, start/data/parity/stop framing, RxRDY/PERR/FERR/OVF.
// Optional RX_MAJORITY_EN: each sample is a 3-clock majority vote instead of a single clock.
module receive_engine #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       Rx,
  input  logic       EIGHT,
  input  logic       PEN,
  input  logic       OHEL,
  input  logic [3:0] BAUD,
  input  logic       read,
  output logic [7:0] rdata,
  output logic       RxRDY,
  output logic       PERR,
  output logic       FERR,
  output logic       OVF
);

  typedef enum logic [1:0] {IDLE, START, DATA, DONE} state_t;

  function automatic logic [18:0] bit_time(input logic [3:0] b);
    case (b)
      4'd0:    bit_time = 19'd333333;
      4'd1:    bit_time = 19'd83333;
      4'd2:    bit_time = 19'd41667;
      4'd3:    bit_time = 19'd20833;
      4'd4:    bit_time = 19'd10417;
      4'd5:    bit_time = 19'd5208;
      4'd6:    bit_time = 19'd2604;
      4'd7:    bit_time = 19'd1736;
      4'd8:    bit_time = 19'd868;
      4'd9:    bit_time = 19'd434;
      4'd10:   bit_time = 19'd217;
      default: bit_time = 19'd109;
    endcase
  endfunction

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rx_s;
  logic                   rx_d1;
  logic                   sample_bit;

  state_t      state;
  logic [18:0] cnt;
  logic [18:0] k_r;
  logic [3:0]  bit_cnt;
  logic [10:0] shreg;
  logic        eight_r;
  logic        pen_r;
  logic        ohel_r;

  logic [3:0]  n_bits;
  logic [10:0] frame_bits;
  logic [7:0]  data_byte;
  logic        par_bit;
  logic        stop_bit;
  logic        perr_calc;
  logic [18:0] half_m1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= '1;
      rx_d1  <= 1'b1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], Rx};
      rx_d1  <= rx_s;
    end
  end

  assign rx_s = sync_q[SYNC_STAGES-1];

  // Sample point is rx_d1 in both builds so latency does not depend on the vote.
`ifdef RX_MAJORITY_EN
  logic rx_d2;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rx_d2 <= 1'b1;
    else      rx_d2 <= rx_d1;
  end

  assign sample_bit = (rx_d2 & rx_d1) | (rx_d1 & rx_s) | (rx_d2 & rx_s);
`else
  assign sample_bit = rx_d1;
`endif

  assign n_bits     = 4'd8 + {3'b000, eight_r} + {3'b000, pen_r};
  assign half_m1    = (k_r >> 1) - 19'd1;
  // The first line bit entered at the top; shift it down to bit 0.
  assign frame_bits = shreg >> (4'd11 - n_bits);
  assign data_byte  = {eight_r & frame_bits[7], frame_bits[6:0]};
  assign par_bit    = frame_bits[eight_r ? 4'd8 : 4'd7];
  assign stop_bit   = frame_bits[n_bits - 4'd1];
  assign perr_calc  = pen_r & ((^data_byte ^ par_bit) != ohel_r);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      cnt     <= '0;
      k_r     <= 19'd109;
      bit_cnt <= '0;
      shreg   <= '0;
      eight_r <= 1'b0;
      pen_r   <= 1'b0;
      ohel_r  <= 1'b0;
      rdata   <= '0;
      RxRDY   <= 1'b0;
      PERR    <= 1'b0;
      FERR    <= 1'b0;
      OVF     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (rx_d1 && !rx_s) begin
            state   <= START;
            cnt     <= '0;
            k_r     <= bit_time(BAUD);
            eight_r <= EIGHT;
            pen_r   <= PEN;
            ohel_r  <= OHEL;
          end
        end
        START: begin
          if (cnt == half_m1) begin
            cnt     <= '0;
            bit_cnt <= '0;
            state   <= sample_bit ? IDLE : DATA;
          end else begin
            cnt <= cnt + 19'd1;
          end
        end
        DATA: begin
          if (cnt == k_r - 19'd1) begin
            cnt     <= '0;
            shreg   <= {sample_bit, shreg[10:1]};
            bit_cnt <= bit_cnt + 4'd1;
            if (bit_cnt + 4'd1 == n_bits) state <= DONE;
          end else begin
            cnt <= cnt + 19'd1;
          end
        end
        DONE: begin
          rdata <= data_byte;
          PERR  <= perr_calc;
          FERR  <= ~stop_bit;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase

      RxRDY <= (state == DONE) | (RxRDY & ~read);
      OVF   <= ((state == DONE) & RxRDY & ~read) | (OVF & ~read);
    end
  end

endmodule
